// File: rtl/mem_access_arbiter_pkg.sv
// Shared definitions for the instruction/data memory access arbiter.
// Holds the fixed-mapping segment constants, the physical address mask, the
// sequencer state encoding and the owner type, plus small segment decoders
// used by the address translator.
package mem_access_arbiter_pkg;

  // Top-nibble values of the two directly mapped segments.
  localparam logic [3:0] KSEG0_LO = 4'h8;
  localparam logic [3:0] KSEG0_HI = 4'h9;
  localparam logic [3:0] KSEG1_LO = 4'hA;
  localparam logic [3:0] KSEG1_HI = 4'hB;

  // Bits kept when a directly mapped address is folded onto physical space.
  localparam logic [28:0] PHYS_MASK = 29'h1fffffff;

  // Sequencer states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  function automatic logic is_kseg0(input logic [3:0] nib);
    return (nib == KSEG0_LO) || (nib == KSEG0_HI);
  endfunction

  function automatic logic is_kseg1(input logic [3:0] nib);
    return (nib == KSEG1_LO) || (nib == KSEG1_HI);
  endfunction

endpackage

// File: rtl/mem_access_arbiter_addr_xlate.sv
// Combinational fixed-mapping address translator.
// Ports:
//   vaddr_i    - virtual address of the current owner
//   paddr_o    - physical address (top three bits cleared in kseg0/kseg1)
//   uncached_o - high when the address lies in kseg1 (uncached window)
module mem_access_arbiter_addr_xlate
  import mem_access_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] vaddr_i,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              uncached_o
);

  logic [3:0] seg;

  assign seg = vaddr_i[ADDR_W-1 -: 4];

  always_comb begin
    paddr_o    = vaddr_i;
    uncached_o = is_kseg1(seg);
    // kseg0 and kseg1 both alias the low 512 MB of physical space.
    if (is_kseg0(seg) || is_kseg1(seg)) begin
      paddr_o = vaddr_i & {{(ADDR_W-29){1'b0}}, PHYS_MASK};
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates the instruction-fetch and data-access requesters onto a single
// downstream memory request port, translating the winner's address.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   inst_req_i/addr_i     - fetch request and virtual address
//   inst_ack_o/rdata_o    - fetch completion pulse and fetched word
//   data_req_i/we_i/wstrb_i/addr_i/wdata_i - load/store request
//   data_ack_o/rdata_o    - load/store completion pulse and load data
//   mem_req_o/we_o/wstrb_o/addr_o/wdata_o/uncached_o - downstream request
//   mem_gnt_i             - downstream accepted the request
//   mem_rvalid_i/rdata_i  - downstream completion and read data
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req_i,
  input  logic [ADDR_W-1:0]   inst_addr_i,
  output logic                inst_ack_o,
  output logic [DATA_W-1:0]   inst_rdata_o,
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [DATA_W/8-1:0] data_wstrb_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic                data_ack_o,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic                mem_uncached_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [1:0]        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_unc_q, mem_unc_d;
  logic              inst_ack_q, inst_ack_d;
  logic              data_ack_q, data_ack_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

  logic              any_req;
  logic              pick_inst;
  logic              win_store;
  logic [ADDR_W-1:0] win_vaddr;
  logic [ADDR_W-1:0] xl_paddr;
  logic              xl_unc;

  // Data wins unless the fetch side has been passed over STARVE_MAX times.
  assign any_req   = inst_req_i | data_req_i;
  assign pick_inst = inst_req_i & (~data_req_i | (starve_q == STARVE_LIM));
  assign win_store = ~pick_inst & data_we_i;
  assign win_vaddr = pick_inst ? inst_addr_i : data_addr_i;

  mem_access_arbiter_addr_xlate #(
    .ADDR_W(ADDR_W)
  ) u_addr_xlate (
    .vaddr_i   (win_vaddr),
    .paddr_o   (xl_paddr),
    .uncached_o(xl_unc)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_unc_d    = mem_unc_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_ack_d   = 1'b0;
    data_ack_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d     = pick_inst ? OWN_INST : OWN_DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = win_store;
          mem_wstrb_d = win_store ? data_wstrb_i : '0;
          mem_addr_d  = xl_paddr;
          mem_wdata_d = pick_inst ? '0 : data_wdata_i;
          mem_unc_d   = xl_unc;
          state_d     = ST_ADDR;
        end
      end
      ST_ADDR: begin
        // Any rvalid coincident with gnt is not a real completion.
        if (mem_gnt_i) begin
          mem_req_d = 1'b0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          if (!mem_we_q) begin
            if (owner_q == OWN_INST) inst_rdata_d = mem_rdata_i;
            else                     data_rdata_d = mem_rdata_i;
          end
          inst_ack_d = (owner_q == OWN_INST);
          data_ack_d = (owner_q == OWN_DATA);
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        // Ack is visible this cycle; no arbitration so a lingering req is not re-served.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Starvation count: data grants taken while a fetch is waiting.
  always_comb begin
    starve_d = starve_q;
    if (!inst_req_i) begin
      starve_d = '0;
    end else if (state_q == ST_IDLE) begin
      if (pick_inst) begin
        starve_d = '0;
      end else if (starve_q != STARVE_LIM) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_INST;
      starve_q     <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wstrb_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_unc_q    <= 1'b0;
      inst_ack_q   <= 1'b0;
      data_ack_q   <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_q     <= starve_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_unc_q    <= mem_unc_d;
      inst_ack_q   <= inst_ack_d;
      data_ack_q   <= data_ack_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign inst_ack_o     = inst_ack_q;
  assign inst_rdata_o   = inst_rdata_q;
  assign data_ack_o     = data_ack_q;
  assign data_rdata_o   = data_rdata_q;
  assign mem_req_o      = mem_req_q;
  assign mem_we_o       = mem_we_q;
  assign mem_wstrb_o    = mem_wstrb_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign mem_uncached_o = mem_unc_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: table of single transactions,
// starvation ordering, gnt stall, spurious downstream strobes and reset in WAIT.
module tb_mem_access_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req_i;
  logic [31:0] inst_addr_i;
  logic        inst_ack_o;
  logic [31:0] inst_rdata_o;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_wstrb_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_ack_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_uncached_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  mem_access_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_req_i    (inst_req_i),
    .inst_addr_i   (inst_addr_i),
    .inst_ack_o    (inst_ack_o),
    .inst_rdata_o  (inst_rdata_o),
    .data_req_i    (data_req_i),
    .data_we_i     (data_we_i),
    .data_wstrb_i  (data_wstrb_i),
    .data_addr_i   (data_addr_i),
    .data_wdata_i  (data_wdata_i),
    .data_ack_o    (data_ack_o),
    .data_rdata_o  (data_rdata_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_wstrb_o   (mem_wstrb_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_uncached_o(mem_uncached_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_data;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gdly;
    int          rdly;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic        exp_unc;
  } vec_t;

  typedef struct {
    logic        own;      // 0 = inst, 1 = data
    logic [31:0] addr;
    logic        unc;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sbq[$];
  int          total;
  int          bad;
  int          lat;
  logic [31:0] last_ird;
  logic [31:0] last_drd;
  vec_t        vt[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"},   {63'd0, mem_req_o}, 64'd0);
    chk({tag, "_we"},    {63'd0, mem_we_o}, 64'd0);
    chk({tag, "_wstrb"}, {60'd0, mem_wstrb_o}, 64'd0);
    chk({tag, "_addr"},  {32'd0, mem_addr_o}, 64'd0);
    chk({tag, "_wdata"}, {32'd0, mem_wdata_o}, 64'd0);
    chk({tag, "_unc"},   {63'd0, mem_uncached_o}, 64'd0);
    chk({tag, "_acks"},  {62'd0, inst_ack_o, data_ack_o}, 64'd0);
    chk({tag, "_irdata"}, {32'd0, inst_rdata_o}, 64'd0);
    chk({tag, "_drdata"}, {32'd0, data_rdata_o}, 64'd0);
  endtask

  // Acts as downstream for one transaction; pops and checks the scoreboard.
  task automatic serve(input int gdly, input int rdly, input logic [31:0] rdata, input bit drop);
    exp_t        e;
    int          k;
    bit          seen;
    logic [31:0] a0;
    seen = 0;
    k    = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (mem_req_o) seen = 1;
    end
    if (!seen) begin
      chk("mem_req_timeout", 64'd0, 64'd1);
      return;
    end
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 64'd0, 64'd1);
      return;
    end
    e = sbq.pop_front();
    chk("mem_addr", {32'd0, mem_addr_o}, {32'd0, e.addr});
    chk("mem_uncached", {63'd0, mem_uncached_o}, {63'd0, e.unc});
    chk("mem_we", {63'd0, mem_we_o}, {63'd0, e.we});
    chk("mem_wstrb", {60'd0, mem_wstrb_o}, {60'd0, e.wstrb});
    if (e.we) chk("mem_wdata", {32'd0, mem_wdata_o}, {32'd0, e.wdata});
    a0 = e.addr;
    for (int i = 0; i < gdly; i++) begin
      mem_gnt_i = 1'b0;
      @(negedge clk);
      k++;
      chk("hold_req", {63'd0, mem_req_o}, 64'd1);
      chk("hold_addr", {32'd0, mem_addr_o}, {32'd0, a0});
      chk("hold_noack", {62'd0, inst_ack_o, data_ack_o}, 64'd0);
    end
    mem_gnt_i = 1'b1;
    @(negedge clk);
    k++;
    mem_gnt_i = 1'b0;
    chk("req_drop_after_gnt", {63'd0, mem_req_o}, 64'd0);
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      k++;
      chk("wait_noack", {62'd0, inst_ack_o, data_ack_o}, 64'd0);
    end
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    @(negedge clk);
    k++;
    mem_rvalid_i = 1'b0;
    lat = k;
    chk("inst_ack", {63'd0, inst_ack_o}, {63'd0, ~e.own});
    chk("data_ack", {63'd0, data_ack_o}, {63'd0, e.own});
    if (!e.we) begin
      if (e.own) last_drd = e.rdata;
      else       last_ird = e.rdata;
    end
    chk("inst_rdata", {32'd0, inst_rdata_o}, {32'd0, last_ird});
    chk("data_rdata", {32'd0, data_rdata_o}, {32'd0, last_drd});
    if (drop) begin
      if (e.own) data_req_i = 1'b0;
      else       inst_req_i = 1'b0;
    end
    @(negedge clk);
    chk("ack_one_cycle", {62'd0, inst_ack_o, data_ack_o}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    total = 0;
    bad   = 0;
    lat   = 0;
    last_ird = '0;
    last_drd = '0;
    rst = 1'b1;
    inst_req_i = 0; inst_addr_i = '0;
    data_req_i = 0; data_we_i = 0; data_wstrb_i = '0; data_addr_i = '0; data_wdata_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;

    //            data we  wstrb  addr          wdata         gd rd rdata         exp_addr      unc
    vt[0] = '{1'b0, 1'b0, 4'h0, 32'hBFC00000, 32'h00000000, 0, 0, 32'h3C1D0000, 32'h1FC00000, 1'b1};
    vt[1] = '{1'b1, 1'b1, 4'h3, 32'h80001004, 32'hDEADBEEF, 0, 0, 32'hFFFF0000, 32'h00001004, 1'b0};
    vt[2] = '{1'b0, 1'b0, 4'h0, 32'h00400000, 32'h00000000, 0, 1, 32'h24080001, 32'h00400000, 1'b0};
    vt[3] = '{1'b1, 1'b0, 4'hF, 32'hA0000010, 32'h00000000, 5, 0, 32'h12345678, 32'h00000010, 1'b1};
    vt[4] = '{1'b1, 1'b0, 4'h0, 32'h9FFFFFFC, 32'h00000000, 0, 2, 32'hCAFEF00D, 32'h1FFFFFFC, 1'b0};
    vt[5] = '{1'b1, 1'b1, 4'hF, 32'hB1234568, 32'h0BADCAFE, 1, 0, 32'hFFFFFFFF, 32'h11234568, 1'b1};
    vt[6] = '{1'b0, 1'b0, 4'h0, 32'hC0000000, 32'h00000000, 0, 0, 32'h8FBF0010, 32'hC0000000, 1'b0};
    vt[7] = '{1'b1, 1'b0, 4'h0, 32'h7FFFFFFF, 32'h00000000, 2, 1, 32'hA5A5A5A5, 32'h7FFFFFFF, 1'b0};

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single transactions from the table.
    for (int v = 0; v < 8; v++) begin
      if (vt[v].is_data) begin
        data_req_i   = 1'b1;
        data_we_i    = vt[v].we;
        data_wstrb_i = vt[v].wstrb;
        data_addr_i  = vt[v].addr;
        data_wdata_i = vt[v].wdata;
      end else begin
        inst_req_i  = 1'b1;
        inst_addr_i = vt[v].addr;
      end
      e.own   = vt[v].is_data;
      e.addr  = vt[v].exp_addr;
      e.unc   = vt[v].exp_unc;
      e.we    = vt[v].is_data & vt[v].we;
      e.wstrb = (vt[v].is_data & vt[v].we) ? vt[v].wstrb : 4'h0;
      e.wdata = vt[v].wdata;
      e.rdata = vt[v].rdata;
      sbq.push_back(e);
      serve(vt[v].gdly, vt[v].rdly, vt[v].rdata, 1'b1);
      chk("latency", lat, 3 + vt[v].gdly + vt[v].rdly);
    end

    // Spurious gnt/rvalid while idle.
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h55555555;
    @(negedge clk);
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    chk("spurious_noack", {62'd0, inst_ack_o, data_ack_o}, 64'd0);
    chk("spurious_noreq", {63'd0, mem_req_o}, 64'd0);
    @(negedge clk);
    chk("spurious_noack2", {62'd0, inst_ack_o, data_ack_o}, 64'd0);
    chk("spurious_irdata", {32'd0, inst_rdata_o}, {32'd0, last_ird});
    chk("spurious_drdata", {32'd0, data_rdata_o}, {32'd0, last_drd});

    // Both requesters held: four data grants, then the fetch, twice over.
    inst_req_i   = 1'b1;
    inst_addr_i  = 32'h00001000;
    data_req_i   = 1'b1;
    data_we_i    = 1'b0;
    data_wstrb_i = 4'h0;
    data_addr_i  = 32'h00002000;
    data_wdata_i = '0;
    for (int i = 0; i < 10; i++) begin
      e.own   = ((i % 5) != 4);
      e.addr  = e.own ? 32'h00002000 : 32'h00001000;
      e.unc   = 1'b0;
      e.we    = 1'b0;
      e.wstrb = 4'h0;
      e.wdata = '0;
      e.rdata = 32'h00000100 + i;
      sbq.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      serve(0, 0, 32'h00000100 + i, 1'b0);
    end
    inst_req_i = 1'b0;
    data_req_i = 1'b0;
    @(negedge clk);
    chk("starve_idle_after", {63'd0, mem_req_o}, 64'd0);
    chk("starve_queue_empty", sbq.size(), 0);

    // Reset while waiting for rvalid.
    data_req_i  = 1'b1;
    data_we_i   = 1'b0;
    data_addr_i = 32'h80000020;
    begin
      int k;
      k = 0;
      while (!mem_req_o && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk("rst_seq_req", {63'd0, mem_req_o}, 64'd1);
      chk("rst_seq_addr", {32'd0, mem_addr_o}, 64'h20);
    end
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    chk("rst_seq_in_wait", {63'd0, mem_req_o}, 64'd0);
    rst        = 1'b1;
    data_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("rst_wait");
    last_ird = '0;
    last_drd = '0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h77777777;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    chk("rst_late_rvalid_noack", {62'd0, inst_ack_o, data_ack_o}, 64'd0);
    @(negedge clk);
    chk("rst_late_rvalid_noack2", {62'd0, inst_ack_o, data_ack_o}, 64'd0);
    chk("rst_late_rvalid_drdata", {32'd0, data_rdata_o}, 64'd0);
    chk("rst_late_rvalid_noreq", {63'd0, mem_req_o}, 64'd0);

    // Fresh fetch after reset.
    inst_req_i  = 1'b1;
    inst_addr_i = 32'h8FC00000;
    e.own   = 1'b0;
    e.addr  = 32'h0FC00000;
    e.unc   = 1'b0;
    e.we    = 1'b0;
    e.wstrb = 4'h0;
    e.wdata = '0;
    e.rdata = 32'h11112222;
    sbq.push_back(e);
    serve(0, 0, 32'h11112222, 1'b1);
    chk("post_rst_latency", lat, 3);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
